// File: rtl/tick_period_monitor_if.sv
`default_nettype none
//==============================================================================
// Module : tick_period_monitor_if
// Desc   : en/tick inputs and measurement results of tick_period_monitor;
//          period_min/period_max present only with TICK_PERIOD_STATS_EN.
// Rev    : 1.0  initial release
//==============================================================================
interface tick_period_monitor_if #(
  parameter int W = 8
);
  logic         en;
  logic         tick;
  logic [W-1:0] period;
  logic         period_valid;
  logic         period_ok;
  logic         timeout;
  logic         locked;
`ifdef TICK_PERIOD_STATS_EN
  logic [W-1:0] period_min;
  logic [W-1:0] period_max;

  modport master (
    output en, tick,
    input  period, period_valid, period_ok, timeout, locked, period_min, period_max
  );
  modport slave (
    input  en, tick,
    output period, period_valid, period_ok, timeout, locked, period_min, period_max
  );
`else
  modport master (
    output en, tick,
    input  period, period_valid, period_ok, timeout, locked
  );
  modport slave (
    input  en, tick,
    output period, period_valid, period_ok, timeout, locked
  );
`endif
endinterface
`default_nettype wire

// File: rtl/tick_period_monitor.sv
`default_nettype none
//==============================================================================
// Module : tick_period_monitor
// Desc   : Measures clk cycles between tick rising edges, checks EXPECT +/- TOL,
//          flags timeout, reports lock. Min/max stats with TICK_PERIOD_STATS_EN.
// Rev    : 1.0  initial release
//==============================================================================
module tick_period_monitor #(
  parameter int W        = 8,
  parameter int EXPECT   = 128,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 arst_n,
  tick_period_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FIRST = 2'd1,
    S_MEASURE    = 2'd2
  } state_t;

  localparam logic [W-1:0] c_cnt_max = {W{1'b1}};
  localparam logic [W-1:0] c_cnt_pre = {{(W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0] c_cnt_one = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   c_expect  = (W+1)'(EXPECT);
  localparam logic [W:0]   c_tol     = (W+1)'(TOL);
  localparam logic [3:0]   c_lock    = 4'(LOCK_CNT);

  state_t       r_state, w_state_nxt;
  logic         r_tick_d;
  logic [W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]   r_lock_run, w_lock_run_nxt;
  logic [W-1:0] r_period, w_period_nxt;
  logic         r_period_valid, w_period_valid_nxt;
  logic         r_period_ok, w_period_ok_nxt;
  logic         r_timeout, w_timeout_nxt;
  logic         r_locked, w_locked_nxt;
  logic         w_clear;
`ifdef TICK_PERIOD_STATS_EN
  logic [W-1:0] r_min, w_min_nxt;
  logic [W-1:0] r_max, w_max_nxt;
`endif

  logic         w_rise;
  logic [W:0]   w_diff;
  logic [W:0]   w_absdiff;
  logic         w_in_tol;

  assign w_rise    = mon.tick & ~r_tick_d;
  // One extra bit keeps cnt < EXPECT from wrapping into a huge positive value
  assign w_diff    = {1'b0, r_cnt} - c_expect;
  assign w_absdiff = w_diff[W] ? -w_diff : w_diff;
  assign w_in_tol  = (w_absdiff <= c_tol) && (r_cnt != c_cnt_max);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_lock_run_nxt     = r_lock_run;
    w_period_nxt       = r_period;
    w_period_valid_nxt = 1'b0;
    w_period_ok_nxt    = r_period_ok;
    w_timeout_nxt      = r_timeout;
    w_locked_nxt       = r_locked;
    w_clear            = 1'b0;
`ifdef TICK_PERIOD_STATS_EN
    w_min_nxt          = r_min;
    w_max_nxt          = r_max;
`endif
    if (!mon.en) begin
      w_state_nxt = S_IDLE;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_WAIT_FIRST;
          w_clear     = 1'b1;
        end
        S_WAIT_FIRST: begin
          if (w_rise) begin
            w_state_nxt = S_MEASURE;
            w_cnt_nxt   = c_cnt_one;
          end
        end
        S_MEASURE: begin
          if (w_rise) begin
            w_period_nxt       = r_cnt;
            w_period_valid_nxt = 1'b1;
            w_period_ok_nxt    = w_in_tol;
            w_cnt_nxt          = c_cnt_one;
            w_timeout_nxt      = 1'b0;
            if (!w_in_tol) begin
              w_lock_run_nxt = 4'd0;
            end else if (r_lock_run < c_lock) begin
              w_lock_run_nxt = r_lock_run + 4'd1;
            end
            w_locked_nxt = (w_lock_run_nxt == c_lock);
`ifdef TICK_PERIOD_STATS_EN
            if (r_cnt < r_min) w_min_nxt = r_cnt;
            if (r_cnt > r_max) w_max_nxt = r_cnt;
`endif
          end else begin
            if (r_cnt != c_cnt_max) begin
              w_cnt_nxt = r_cnt + c_cnt_one;
            end
            // Timeout rises together with cnt reaching its saturation value
            if (r_cnt == c_cnt_pre) begin
              w_timeout_nxt  = 1'b1;
              w_lock_run_nxt = 4'd0;
              w_locked_nxt   = 1'b0;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end
      endcase
    end

    if (w_clear) begin
      w_cnt_nxt      = '0;
      w_lock_run_nxt = 4'd0;
      w_timeout_nxt  = 1'b0;
      w_locked_nxt   = 1'b0;
`ifdef TICK_PERIOD_STATS_EN
      w_min_nxt      = c_cnt_max;
      w_max_nxt      = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_tick_d       <= 1'b0;
      r_cnt          <= '0;
      r_lock_run     <= 4'd0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_period_ok    <= 1'b0;
      r_timeout      <= 1'b0;
      r_locked       <= 1'b0;
`ifdef TICK_PERIOD_STATS_EN
      r_min          <= c_cnt_max;
      r_max          <= '0;
`endif
    end else begin
      r_tick_d       <= mon.tick;
      r_cnt          <= w_cnt_nxt;
      r_lock_run     <= w_lock_run_nxt;
      r_period       <= w_period_nxt;
      r_period_valid <= w_period_valid_nxt;
      r_period_ok    <= w_period_ok_nxt;
      r_timeout      <= w_timeout_nxt;
      r_locked       <= w_locked_nxt;
`ifdef TICK_PERIOD_STATS_EN
      r_min          <= w_min_nxt;
      r_max          <= w_max_nxt;
`endif
    end
  end

  assign mon.period       = r_period;
  assign mon.period_valid = r_period_valid;
  assign mon.period_ok    = r_period_ok;
  assign mon.timeout      = r_timeout;
  assign mon.locked       = r_locked;
`ifdef TICK_PERIOD_STATS_EN
  assign mon.period_min   = r_min;
  assign mon.period_max   = r_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tick_period_monitor.sv
`default_nettype none
//==============================================================================
// Module : tb_tick_period_monitor
// Desc   : Self-checking bench for tick_period_monitor (W=8, EXPECT=128, TOL=0,
//          LOCK_CNT=4); stats outputs checked when TICK_PERIOD_STATS_EN is set.
// Rev    : 1.0  initial release
//==============================================================================
module tb_tick_period_monitor;

  localparam int W        = 8;
  localparam int EXPECT   = 128;
  localparam int TOL      = 0;
  localparam int LOCK_CNT = 4;

  logic clk    = 1'b0;
  logic arst_n = 1'b1;
  logic tb_en  = 1'b0;
  logic tb_tick = 1'b0;

  tick_period_monitor_if #(.W(W)) mon_if ();

  assign mon_if.en   = tb_en;
  assign mon_if.tick = tb_tick;

  tick_period_monitor #(
    .W        (W),
    .EXPECT   (EXPECT),
    .TOL      (TOL),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .mon    (mon_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: event times in edge numbers, outputs derived arithmetically
  int         m_k;
  bit         m_tick_d;
  bit         m_active;
  bit         m_started;
  int         m_last;
  int         m_run;
  bit         e_pv;
  logic [7:0] e_period;
  bit         e_ok;
  bit         e_to;
  bit         e_lk;
  int         e_min;
  int         e_max;

  task automatic model_reset();
    m_tick_d  = 1'b0;
    m_active  = 1'b0;
    m_started = 1'b0;
    m_run     = 0;
    e_pv      = 1'b0;
    e_period  = 8'd0;
    e_ok      = 1'b0;
    e_to      = 1'b0;
    e_lk      = 1'b0;
    e_min     = 255;
    e_max     = 0;
  endtask

  task automatic model_edge(input bit en_i, input bit tick_i);
    bit rise;
    int el;
    int p;
    int d;
    rise     = tick_i && !m_tick_d;
    m_tick_d = tick_i;
    m_k++;
    e_pv = 1'b0;
    if (!en_i || !m_active) begin
      m_active  = en_i;
      m_started = 1'b0;
      m_run     = 0;
      e_lk      = 1'b0;
      e_to      = 1'b0;
      e_min     = 255;
      e_max     = 0;
    end else if (!m_started) begin
      if (rise) begin
        m_started = 1'b1;
        m_last    = m_k;
      end
    end else begin
      el = m_k - m_last;
      p  = (el > 255) ? 255 : el;
      if (rise) begin
        d = p - EXPECT;
        if (d < 0) d = -d;
        e_pv     = 1'b1;
        e_period = 8'(p);
        e_ok     = (d <= TOL) && (p < 255);
        e_to     = 1'b0;
        m_run    = e_ok ? ((m_run + 1 > LOCK_CNT) ? LOCK_CNT : m_run + 1) : 0;
        e_lk     = (m_run == LOCK_CNT);
        if (p < e_min) e_min = p;
        if (p > e_max) e_max = p;
        m_last = m_k;
      end else if (el >= 254) begin
        e_to  = 1'b1;
        m_run = 0;
        e_lk  = 1'b0;
      end
    end
  endtask

  task automatic check(input string name);
    bit bad;
    n_vec++;
    bad = (mon_if.period_valid !== e_pv) || (mon_if.period !== e_period) ||
          (mon_if.period_ok !== e_ok) || (mon_if.timeout !== e_to) || (mon_if.locked !== e_lk);
`ifdef TICK_PERIOD_STATS_EN
    bad = bad || (mon_if.period_min !== 8'(e_min)) || (mon_if.period_max !== 8'(e_max));
`endif
    if (bad) begin
      n_err++;
      $display("FAIL %s @%0t: got pv=%b period=%0d ok=%b timeout=%b locked=%b, want pv=%b period=%0d ok=%b timeout=%b locked=%b",
               name, $time, mon_if.period_valid, mon_if.period, mon_if.period_ok, mon_if.timeout,
               mon_if.locked, e_pv, e_period, e_ok, e_to, e_lk);
`ifdef TICK_PERIOD_STATS_EN
      $display("FAIL %s stats: got min=%0d max=%0d, want min=%0d max=%0d",
               name, mon_if.period_min, mon_if.period_max, e_min, e_max);
`endif
    end
  endtask

  task automatic check_exp(input string name, input bit pv, input int per, input bit ok,
                           input bit to, input bit lk);
    n_vec++;
    if ((mon_if.period_valid !== pv) || (mon_if.period !== 8'(per)) || (mon_if.period_ok !== ok) ||
        (mon_if.timeout !== to) || (mon_if.locked !== lk)) begin
      n_err++;
      $display("FAIL %s: got pv=%b period=%0d ok=%b timeout=%b locked=%b, want pv=%b period=%0d ok=%b timeout=%b locked=%b",
               name, mon_if.period_valid, mon_if.period, mon_if.period_ok, mon_if.timeout,
               mon_if.locked, pv, per, ok, to, lk);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    #1;
    model_edge(tb_en, tb_tick);
    check(name);
  endtask

  task automatic apply_reset();
    tb_tick = 1'b0;
    arst_n  = 1'b0;
    #2;
    model_reset();
    check("async_reset");
    check_exp("reset_zero", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
  endtask

  task automatic lows(input int n, input string name);
    tb_tick = 1'b0;
    repeat (n) step(name);
  endtask

  typedef struct {
    bit en;
    int low;
    int hold;
    bit pv;
    int period;
    bit ok;
    bit lk;
  } row_t;

  row_t tbl [15];

  initial begin
    int prev_hold;
    int sel;
    int hold;
    int spacing;
    int low;

    tbl[0]  = '{1'b1,  10, 1, 1'b0,   0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 127, 1, 1'b1, 128, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 127, 1, 1'b1, 128, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 127, 1, 1'b1, 128, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 127, 1, 1'b1, 128, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 129, 1, 1'b1, 130, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 127, 1, 1'b1, 128, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 127, 1, 1'b1, 128, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 127, 1, 1'b1, 128, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 127, 1, 1'b1, 128, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 127, 5, 1'b1, 128, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 123, 5, 1'b1, 128, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 121, 5, 1'b1, 126, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 125, 5, 1'b1, 130, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 123, 5, 1'b1, 128, 1'b1, 1'b0};

    m_k = 0;
    #2;
    apply_reset();

    // Table: steady strobe, lock/unlock/relock, held-high ticks
    for (int i = 0; i < 15; i++) begin
      tb_en = tbl[i].en;
      lows(tbl[i].low, "tbl_low");
      tb_tick = 1'b1;
      step("tbl_rise");
      check_exp($sformatf("tbl_row%0d", i), tbl[i].pv, tbl[i].period, tbl[i].ok, 1'b0, tbl[i].lk);
      repeat (tbl[i].hold - 1) step("tbl_hold");
    end
`ifdef TICK_PERIOD_STATS_EN
    n_vec++;
    if (mon_if.period_min !== 8'd126 || mon_if.period_max !== 8'd130) begin
      n_err++;
      $display("FAIL stats_minmax: got min=%0d max=%0d, want min=126 max=130",
               mon_if.period_min, mon_if.period_max);
    end
`endif

    // Timeout: rise edge was 4 hold steps ago
    lows(249, "to_wait");
    check_exp("to_before", 1'b0, 128, 1'b1, 1'b0, 1'b0);
    step("to_set");
    check_exp("to_at_254", 1'b0, 128, 1'b1, 1'b1, 1'b0);
    lows(10, "to_hold");
    tb_tick = 1'b1;
    step("to_rise");
    check_exp("to_rise_255", 1'b1, 255, 1'b0, 1'b0, 1'b0);

    // Rise exactly at saturation, then one cycle before it
    lows(254, "sat_wait");
    tb_tick = 1'b1;
    step("sat_rise");
    check_exp("sat_255", 1'b1, 255, 1'b0, 1'b0, 1'b0);
    lows(253, "pre_wait");
    tb_tick = 1'b1;
    step("pre_rise");
    check_exp("pre_254", 1'b1, 254, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a measurement
    lows(50, "mid_meas");
    apply_reset();
    lows(20, "rst_wait");
    tb_tick = 1'b1;
    step("rst_first");
    check_exp("rst_first_novalid", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    lows(127, "rst_gap");
    tb_tick = 1'b1;
    step("rst_second");
    check_exp("rst_second_128", 1'b1, 128, 1'b1, 1'b0, 1'b0);

    // en low for 3 cycles with a rise inside the window
    lows(40, "en_pre");
    tb_en = 1'b0;
    step("en_off0");
    tb_tick = 1'b1;
    step("en_off_rise");
    check_exp("en_off_novalid", 1'b0, 128, 1'b1, 1'b0, 1'b0);
    tb_tick = 1'b0;
    step("en_off2");
    tb_en = 1'b1;
    lows(30, "en_on");
    tb_tick = 1'b1;
    step("en_first");
    check_exp("en_first_novalid", 1'b0, 128, 1'b1, 1'b0, 1'b0);
    lows(127, "en_gap");
    tb_tick = 1'b1;
    step("en_second");
    check_exp("en_second_128", 1'b1, 128, 1'b1, 1'b0, 1'b0);

    // Randomized spacing, hold, enable drops and resets against the model
    prev_hold = 1;
    for (int ev = 0; ev < 150; ev++) begin
      sel  = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 4));
      if (sel < 6) spacing = EXPECT - 1 + int'($urandom_range(0, 2));
      else         spacing = int'($urandom_range(2, 300));
      low = spacing - prev_hold;
      if (low < 1) low = 1;
      if ($urandom_range(0, 59) == 0) apply_reset();
      tb_tick = 1'b0;
      for (int j = 0; j < low; j++) begin
        tb_en = ($urandom_range(0, 199) != 0);
        step("rnd_low");
      end
      tb_tick = 1'b1;
      for (int j = 0; j < hold; j++) begin
        step("rnd_high");
      end
      prev_hold = hold;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
